segmented_phase_accumulator: RTL and testbench
==============================================

Name: segmented_phase_accumulator

Overview:
- Parametrised successor to the fixed-width ripple adders. A WIDTH-bit phase accumulator for the oscillator path.
- Each sample tick adds a frequency word to the phase register.
- The carry chain is evaluated one SEG_BITS-wide segment per clock, so wide accumulators meet timing on the FPGA.
- Produces the phase for the waveform lookup, plus a wrap pulse for oscillator sync.

Parameters:
- WIDTH, 24, accumulator and frequency-word width in bits.
- SEG_BITS, 8, bits added per clock. WIDTH must be an integer multiple of SEG_BITS; otherwise elaboration fails. NSEG = WIDTH/SEG_BITS, and NSEG >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- tick  in  1  sample strobe; requests one accumulation.
- freq_word  in  WIDTH  phase increment (unsigned).
- freq_load  in  1  loads freq_word into the increment register.
- phase_reset  in  1  synchronous phase clear (oscillator hard sync).
- overrun_clr  in  1  clears the overrun flag.
- phase_out  out  WIDTH  current phase.
- done  out  1  one-cycle pulse when phase_out updates.
- wrap  out  1  one-cycle pulse, coincident with done, on modular wrap.
- busy  out  1  accumulation in progress.
- overrun  out  1  sticky: a tick was dropped.

Behaviour:
- Reset (rst_n=0 at a rising edge): phase_out=0, increment register=0, done=0, wrap=0, busy=0, overrun=0, state=IDLE, segment counter=0.
- Priority per edge: rst_n > phase_reset > everything else.
- freq_load:
  - Accepted in any state; the increment register takes freq_word at that edge.
  - If freq_load and tick are sampled at the same edge in IDLE, the new freq_word is used for that accumulation.
- States:
  - IDLE:
    - tick=1 -> snapshot the increment register and phase_out into working registers; carry=0; seg=0; busy=1; go to ADD.
    - tick=0 -> stay in IDLE.
  - ADD:
    - At each edge: working segment seg = acc_seg + inc_seg + carry. The segment's carry-out is registered for the next segment; seg increments.
    - At the edge completing segment NSEG-1:
      - phase_out <= full working result, modulo 2^WIDTH;
      - done=1 for exactly one cycle;
      - wrap = final carry-out;
      - busy=0; go to IDLE.
- Latency: tick sampled at edge E0 -> phase_out, done and wrap update at edge E(NSEG). NSEG=1 gives a single-cycle ADD.
- Maximum accepted tick rate: one per NSEG+1 clocks.
- phase_out updates atomically. It holds the previous value for the whole of ADD, and partial segment sums are never visible.
- tick while busy=1:
  - the tick is ignored and overrun is set to 1;
  - the in-flight operation continues unaffected.
- overrun:
  - cleared only by overrun_clr or rst_n;
  - if overrun_clr and a dropped tick occur at the same edge, set wins (overrun=1).
- phase_reset, in any state:
  - phase_out=0, state=IDLE, busy=0, carry=0, seg=0;
  - the in-flight result is discarded with no done or wrap pulse;
  - the increment register and overrun are unchanged;
  - a tick at the same edge is ignored and not counted as an overrun.
- done and wrap are 0 in every cycle except the completion cycle.

Optional Feature:
- Macro: SEGMENTED_PHASE_ACC_DIR_EN.
- Defined:
  - Adds input dir (1 bit), captured at operation start along with the increment snapshot.
  - dir=0: addition as above.
  - dir=1: phase decrements. The operand is ~increment, with carry-in 1 on segment 0.
  - In decrement mode wrap = NOT final carry (borrow). Decrementing by 0 gives no wrap.
- Undefined: the dir port does not exist; behaviour is addition only.

Test Plan:
- Reset: hold rst_n=0 two edges with tick=1 -> phase_out=0, busy=0, done=0, wrap=0, overrun=0. No activity until rst_n=1.
- Carry across segments (WIDTH=24, SEG_BITS=8): load 0x0000FF, tick, wait 4 clocks, tick again:
  - first done at E3 with phase_out=0x0000FF;
  - second result 0x0001FE, wrap=0;
  - phase_out constant between updates.
- Wrap: load 0x800000, two ticks -> 0x800000 with wrap=0, then 0x000000 with wrap=1 coincident with done.
- Overrun: tick, then tick 1 clock later (busy=1) -> overrun=1 and a single result. Then overrun_clr -> overrun=0. Same-edge overrun_clr plus dropped tick -> overrun=1.
- phase_reset mid-ADD: phase_out=0x123456, tick, assert phase_reset on the following edge -> phase_out=0, busy=0, no done/wrap pulse. Next tick with increment 0x000010 yields 0x000010.
- With SEGMENTED_PHASE_ACC_DIR_EN: phase 0, dir=1, increment 1 -> 0xFFFFFF with wrap=1. Then dir=0, increment 1 -> 0x000000 with wrap=1.

Source files
------------

// File: rtl/segmented_phase_accumulator.sv
// segmented_phase_accumulator
//   WIDTH-bit phase accumulator for the oscillator path. Each accepted sample
//   tick adds the increment register to the phase. The carry chain is
//   evaluated one SEG_BITS-wide segment per clock (NSEG = WIDTH/SEG_BITS
//   clocks per accumulation), so wide accumulators stay short in logic depth.
//   phase_out only changes on the completion edge, never showing partial sums.
//
// Optional feature macro: SEGMENTED_PHASE_ACC_DIR_EN
//   When defined, adds input 'dir' (captured at operation start):
//   0 = increment, 1 = decrement (wrap then flags a borrow).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   tick         sample strobe, requests one accumulation
//   freq_word    phase increment (unsigned)
//   freq_load    loads freq_word into the increment register
//   phase_reset  synchronous phase clear (hard sync), aborts any operation
//   overrun_clr  clears the sticky overrun flag
//   dir          (optional) direction, see above
//   phase_out    current phase
//   done         one-cycle pulse when phase_out updates
//   wrap         one-cycle pulse, coincident with done, on modular wrap
//   busy         accumulation in progress
//   overrun      sticky: a tick arrived while busy and was dropped
module segmented_phase_accumulator #(
  parameter int WIDTH    = 24,
  parameter int SEG_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] freq_word,
  input  logic             freq_load,
  input  logic             phase_reset,
  input  logic             overrun_clr,
`ifdef SEGMENTED_PHASE_ACC_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] phase_out,
  output logic             done,
  output logic             wrap,
  output logic             busy,
  output logic             overrun
);

  localparam int NSEG   = WIDTH / SEG_BITS;
  localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;

  generate
    if ((WIDTH % SEG_BITS) != 0 || NSEG < 1) begin : g_bad_params
      $error("segmented_phase_accumulator: WIDTH must be a positive multiple of SEG_BITS");
    end
  endgenerate

  typedef enum logic {IDLE, ADD} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    inc_reg;       // programmed increment
  logic [WIDTH-1:0]    acc_work_reg;  // phase snapshot at operation start
  logic [WIDTH-1:0]    inc_work_reg;  // increment snapshot at operation start
  logic [WIDTH-1:0]    sum_work_reg;  // segments completed so far
  logic                carry_reg;
  logic                dir_reg;
  logic [SEG_CW-1:0]   seg_cnt_reg;

  logic                dir_in;
  logic [SEG_BITS-1:0] acc_seg_arr [NSEG];
  logic [SEG_BITS-1:0] inc_seg_arr [NSEG];
  logic [SEG_BITS-1:0] acc_seg;
  logic [SEG_BITS-1:0] op_seg;
  logic [SEG_BITS:0]   seg_sum;
  logic [WIDTH-1:0]    result_next;
  logic                seg_is_last;

`ifdef SEGMENTED_PHASE_ACC_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // Slice the working words into segments, and merge the current segment's
  // sum into the partial result word.
  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      assign acc_seg_arr[gi] = acc_work_reg[gi*SEG_BITS +: SEG_BITS];
      assign inc_seg_arr[gi] = inc_work_reg[gi*SEG_BITS +: SEG_BITS];
      assign result_next[gi*SEG_BITS +: SEG_BITS] =
        (seg_cnt_reg == SEG_CW'(gi)) ? seg_sum[SEG_BITS-1:0]
                                     : sum_work_reg[gi*SEG_BITS +: SEG_BITS];
    end
  endgenerate

  // Decrement is two's-complement subtraction: ~increment with carry-in 1,
  // the carry-in being preloaded into carry_reg at operation start.
  assign acc_seg     = acc_seg_arr[seg_cnt_reg];
  assign op_seg      = dir_reg ? ~inc_seg_arr[seg_cnt_reg] : inc_seg_arr[seg_cnt_reg];
  assign seg_sum     = {1'b0, acc_seg} + {1'b0, op_seg} + {{SEG_BITS{1'b0}}, carry_reg};
  assign seg_is_last = (seg_cnt_reg == SEG_CW'(NSEG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      inc_reg      <= '0;
      acc_work_reg <= '0;
      inc_work_reg <= '0;
      sum_work_reg <= '0;
      carry_reg    <= 1'b0;
      dir_reg      <= 1'b0;
      seg_cnt_reg  <= '0;
      phase_out    <= '0;
      done         <= 1'b0;
      wrap         <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (phase_reset) begin
        // Hard sync: drop the in-flight result; increment and overrun kept.
        phase_out   <= '0;
        state_reg   <= IDLE;
        busy        <= 1'b0;
        carry_reg   <= 1'b0;
        seg_cnt_reg <= '0;
      end else begin
        if (freq_load) begin
          inc_reg <= freq_word;
        end
        // Set wins over clear when both happen at the same edge.
        if (tick && busy) begin
          overrun <= 1'b1;
        end else if (overrun_clr) begin
          overrun <= 1'b0;
        end

        case (state_reg)
          IDLE: begin
            if (tick) begin
              acc_work_reg <= phase_out;
              inc_work_reg <= freq_load ? freq_word : inc_reg;
              dir_reg      <= dir_in;
              carry_reg    <= dir_in;
              seg_cnt_reg  <= '0;
              busy         <= 1'b1;
              state_reg    <= ADD;
            end
          end
          ADD: begin
            sum_work_reg <= result_next;
            carry_reg    <= seg_sum[SEG_BITS];
            if (seg_is_last) begin
              phase_out   <= result_next;
              done        <= 1'b1;
              // Without a final carry a decrement has borrowed below zero.
              wrap        <= seg_sum[SEG_BITS] ^ dir_reg;
              busy        <= 1'b0;
              carry_reg   <= 1'b0;
              seg_cnt_reg <= '0;
              state_reg   <= IDLE;
            end else begin
              seg_cnt_reg <= seg_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segmented_phase_accumulator.sv
// Directed testbench for segmented_phase_accumulator (WIDTH=24, SEG_BITS=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_segmented_phase_accumulator;

  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic [WIDTH-1:0] freq_word;
  logic             freq_load;
  logic             phase_reset;
  logic             overrun_clr;
`ifdef SEGMENTED_PHASE_ACC_DIR_EN
  logic             dir;
`endif
  logic [WIDTH-1:0] phase_out;
  logic             done;
  logic             wrap;
  logic             busy;
  logic             overrun;

  int n_vec = 0;
  int n_err = 0;

  segmented_phase_accumulator #(.WIDTH(WIDTH), .SEG_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .freq_word   (freq_word),
    .freq_load   (freq_load),
    .phase_reset (phase_reset),
    .overrun_clr (overrun_clr),
`ifdef SEGMENTED_PHASE_ACC_DIR_EN
    .dir         (dir),
`endif
    .phase_out   (phase_out),
    .done        (done),
    .wrap        (wrap),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %-16s got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %-16s got %h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick (optionally with a same-edge freq_load), then wait for done.
  task automatic do_tick(input logic load, output logic [WIDTH-1:0] ph, output logic wr);
    logic got;
    got = 1'b0;
    ph  = '0;
    wr  = 1'b0;
    tick      = 1'b1;
    freq_load = load;
    step();
    tick      = 1'b0;
    freq_load = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (done) begin
        got = 1'b1;
        ph  = phase_out;
        wr  = wrap;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic load_inc(input logic [WIDTH-1:0] w);
    freq_word = w;
    freq_load = 1'b1;
    step();
    freq_load = 1'b0;
  endtask

  task automatic sync_reset();
    phase_reset = 1'b1;
    step();
    phase_reset = 1'b0;
  endtask

  logic [WIDTH-1:0] ph;
  logic             wr;
  int               n_done;

  initial begin
    rst_n = 1'b0; tick = 1'b1; freq_word = 24'hABCDEF; freq_load = 1'b0;
    phase_reset = 1'b0; overrun_clr = 1'b0;
`ifdef SEGMENTED_PHASE_ACC_DIR_EN
    dir = 1'b0;
`endif
    // Reset held two edges with tick high
    step(); step();
    chk("rst_phase", 32'(phase_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1; tick = 1'b0;
    step();

    // Carry across segments, latency NSEG=3
    load_inc(24'h0000FF);
    tick = 1'b1; step(); tick = 1'b0;         // E0
    chk("c1_busy_e0", 32'(busy), 32'h1);
    step();                                    // E1
    chk("c1_phase_e1", 32'(phase_out), 32'h0);
    chk("c1_done_e1", 32'(done), 32'h0);
    step();                                    // E2
    chk("c1_phase_e2", 32'(phase_out), 32'h0);
    step();                                    // E3
    chk("c1_done_e3", 32'(done), 32'h1);
    chk("c1_phase_e3", 32'(phase_out), 32'h0000FF);
    chk("c1_busy_e3", 32'(busy), 32'h0);
    step();
    chk("c1_done_e4", 32'(done), 32'h0);
    chk("c1_hold_e4", 32'(phase_out), 32'h0000FF);
    do_tick(1'b0, ph, wr);
    chk("c2_phase", 32'(ph), 32'h0001FE);
    chk("c2_wrap", 32'(wr), 32'h0);

    // Wrap
    sync_reset();
    load_inc(24'h800000);
    do_tick(1'b0, ph, wr);
    chk("w1_phase", 32'(ph), 32'h800000);
    chk("w1_wrap", 32'(wr), 32'h0);
    do_tick(1'b0, ph, wr);
    chk("w2_phase", 32'(ph), 32'h000000);
    chk("w2_wrap", 32'(wr), 32'h1);
    step();
    chk("w2_wrap_clear", 32'(wrap), 32'h0);

    // Overrun: second tick while busy is dropped
    tick = 1'b1; step(); tick = 1'b0;          // E0, phase 0 + 0x800000
    step();
    tick = 1'b1; step(); tick = 1'b0;          // E2, busy
    chk("ov_set", 32'(overrun), 32'h1);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    chk("ov_one_result", 32'(n_done), 32'd1);
    chk("ov_phase", 32'(phase_out), 32'h800000);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'h0);
    tick = 1'b1; step();                       // E0
    overrun_clr = 1'b1; step();                // dropped tick + clear
    tick = 1'b0; overrun_clr = 1'b0;
    chk("ov_set_wins", 32'(overrun), 32'h1);
    step(); step();
    chk("ov_phase2", 32'(phase_out), 32'h000000);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("ov_cleared2", 32'(overrun), 32'h0);

    // phase_reset mid-ADD
    sync_reset();
    load_inc(24'h123456);
    do_tick(1'b0, ph, wr);
    chk("pr_setup", 32'(ph), 32'h123456);
    load_inc(24'h000010);
    tick = 1'b1; step();                       // E0
    phase_reset = 1'b1;                        // tick still high, ignored
    step();
    tick = 1'b0; phase_reset = 1'b0;
    chk("pr_phase", 32'(phase_out), 32'h0);
    chk("pr_busy", 32'(busy), 32'h0);
    chk("pr_done", 32'(done), 32'h0);
    chk("pr_no_overrun", 32'(overrun), 32'h0);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || wrap) n_done++;
    end
    chk("pr_no_pulse", 32'(n_done), 32'd0);
    do_tick(1'b0, ph, wr);
    chk("pr_next", 32'(ph), 32'h000010);

    // freq_load and tick at the same edge: new word used
    freq_word = 24'h000005;
    do_tick(1'b1, ph, wr);
    chk("ld_same_edge", 32'(ph), 32'h000015);

`ifdef SEGMENTED_PHASE_ACC_DIR_EN
    sync_reset();
    load_inc(24'h000001);
    dir = 1'b1;
    do_tick(1'b0, ph, wr);
    chk("dec_phase", 32'(ph), 32'hFFFFFF);
    chk("dec_wrap", 32'(wr), 32'h1);
    dir = 1'b0;
    do_tick(1'b0, ph, wr);
    chk("inc_phase", 32'(ph), 32'h000000);
    chk("inc_wrap", 32'(wr), 32'h1);
    load_inc(24'h000000);
    dir = 1'b1;
    do_tick(1'b0, ph, wr);
    chk("dec0_phase", 32'(ph), 32'h000000);
    chk("dec0_wrap", 32'(wr), 32'h0);
    dir = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
